// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the NoC processing node, router and master.
//   - tx_state_t : TX FSM states (IDLE / REQ / SEND)
//   - flit_last  : bit index of the last-flag inside a DATA_W+1 bit flit
//   - DEFAULT_DATA_W / DEFAULT_NODE_CNT : network-wide default sizing
package noc_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NODE_CNT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  // The last-flag sits directly above the payload.
  function automatic int flit_last(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/noc_rx_monitor.sv
// noc_rx_monitor: inbound flit statistics and sequence-integrity check.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   flit_data         {last, payload} from the router
//   flit_valid        flit_data valid this cycle
//   flit_count        flits received, saturating at all-ones
//   pkt_count         last-flits received, wrapping
//   seq_error         sticky payload-sequence mismatch, cleared by reset only
module noc_rx_monitor
  import noc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W:0]   flit_data,
  input  logic              flit_valid,
  output logic [CNT_W-1:0]  flit_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic              seq_error
);

  localparam int LAST = flit_last(DATA_W);

  logic [DATA_W-1:0] exp_reg;
  logic [DATA_W-1:0] payload;
  logic              last;

  assign payload = flit_data[DATA_W-1:0];
  assign last    = flit_data[LAST];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flit_count <= '0;
      pkt_count  <= '0;
      seq_error  <= 1'b0;
      exp_reg    <= DATA_W'(1);
    end else if (flit_valid) begin
      if (flit_count != '1)
        flit_count <= flit_count + CNT_W'(1);
      if (last)
        pkt_count <= pkt_count + CNT_W'(1);
      if (payload != exp_reg)
        seq_error <= 1'b1;
      // Track the received payload rather than the old expectation so a single
      // corrupted flit does not cascade into errors on every following flit.
      exp_reg <= last ? DATA_W'(1) : payload + DATA_W'(1);
    end
  end

endmodule

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: NoC processing node.
// Accepts burst commands, requests a slot from the crossbar master, streams
// numbered flits {last, payload} under valid/ready, and monitors inbound
// traffic through noc_rx_monitor.
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          burst command handshake (cmd_dest, cmd_len)
//   req/req_dest/grant           slot request to the crossbar master
//   tx_data/tx_valid/tx_ready    outbound flit stream
//   rx_data/rx_valid             inbound flit stream (no backpressure)
//   busy                         high whenever the TX FSM is not IDLE
//   rx_flit_count/rx_pkt_count   receive statistics
//   rx_error                     sticky receive sequence error
module noc_traffic_node
  import noc_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NODE_CNT = DEFAULT_NODE_CNT,
  parameter int DEST_W   = $clog2(NODE_CNT),
  parameter int LEN_W    = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DEST_W-1:0] cmd_dest,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  output logic [DEST_W-1:0] req_dest,
  input  logic              grant,
  output logic [DATA_W:0]   tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W:0]   rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  rx_flit_count,
  output logic [CNT_W-1:0]  rx_pkt_count,
  output logic              rx_error
);

  localparam int               LAST    = flit_last(DATA_W);
  localparam logic [LEN_W-1:0] SEQ_ONE = LEN_W'(1);

  tx_state_t        state;
  logic [LEN_W-1:0] seq_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] seq_inc;

  assign seq_inc   = seq_reg + SEQ_ONE;
  assign cmd_ready = (state == IDLE);

  // Payload is seq resized to DATA_W (truncated or zero-extended); last is set
  // on the flit whose number equals the burst length.
  function automatic logic [DATA_W:0] make_flit(input logic [LEN_W-1:0] s,
                                                input logic [LEN_W-1:0] l);
    logic [DATA_W:0] f;
    f                = '0;
    f[DATA_W-1:0]    = DATA_W'(s);
    f[LAST]          = (s == l);
    return f;
  endfunction

  // tx_data is preloaded one cycle ahead (on grant or on each handshake) so
  // that it can be a plain register and still change on every accepted flit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      seq_reg  <= '0;
      len_reg  <= '0;
      req      <= 1'b0;
      req_dest <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // A zero-length command is consumed here without issuing a request.
          if (cmd_valid && (cmd_len != '0)) begin
            len_reg  <= cmd_len;
            seq_reg  <= SEQ_ONE;
            req      <= 1'b1;
            req_dest <= cmd_dest;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (grant) begin
            req      <= 1'b0;
            tx_valid <= 1'b1;
            tx_data  <= make_flit(seq_reg, len_reg);
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (tx_data[LAST]) begin
              tx_valid <= 1'b0;
              tx_data  <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              seq_reg <= seq_inc;
              tx_data <= make_flit(seq_inc, len_reg);
            end
          end
        end
        default: begin
          state    <= IDLE;
          req      <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  noc_rx_monitor #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rx_monitor (
    .clock      (clock),
    .reset      (reset),
    .flit_data  (rx_data),
    .flit_valid (rx_valid),
    .flit_count (rx_flit_count),
    .pkt_count  (rx_pkt_count),
    .seq_error  (rx_error)
  );

endmodule

// File: tb/tb_noc_traffic_node.sv
// Testbench for noc_traffic_node: burst table, rx table, and hand-written
// sequences for zero-length commands, maximum length and mid-burst reset.
module tb_noc_traffic_node;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dest;
  logic [7:0]  cmd_len;
  logic        req;
  logic [1:0]  req_dest;
  logic        grant;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic [15:0] rx_flit_count;
  logic [15:0] rx_pkt_count;
  logic        rx_error;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];

  noc_traffic_node dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dest      (cmd_dest),
    .cmd_len       (cmd_len),
    .req           (req),
    .req_dest      (req_dest),
    .grant         (grant),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .busy          (busy),
    .rx_flit_count (rx_flit_count),
    .rx_pkt_count  (rx_pkt_count),
    .rx_error      (rx_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [8:0] flit(input int idx, input int len);
    logic [7:0] p;
    p = 8'(idx);
    return {(idx == len), p};
  endfunction

  // Scoreboard consumer: every accepted flit must match the oldest expected one.
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got flit 0x%0h expected none", tx_data);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        check("sb_flit", 32'(tx_data), 32'(e));
        $display("tx flit 0x%03h (expected 0x%03h)", tx_data, e);
      end
    end
  end

  typedef struct {
    int dest;
    int len;
    int gdelay;
    int stall_idx;
    int stall_cycles;
  } burst_t;

  typedef struct {
    logic       valid;
    logic [8:0] data;
    int         flits;
    int         pkts;
    logic       err;
  } rx_vec_t;

  task automatic run_burst(input burst_t b);
    int idx;
    int stall_left;
    int held;
    int cyc;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    for (int i = 1; i <= b.len; i++) sb.push_back(flit(i, b.len));
    cmd_valid = 1'b1;
    cmd_dest  = 2'(b.dest);
    cmd_len   = 8'(b.len);
    tick();
    cmd_valid = 1'b0;
    check("busy_req", 32'(busy), 32'd1);
    check("cmd_ready_req", 32'(cmd_ready), 32'd0);
    for (int i = 1; i <= b.gdelay; i++) begin
      check("req", 32'(req), 32'd1);
      check("req_dest", 32'(req_dest), 32'(b.dest));
      check("tx_valid_req", 32'(tx_valid), 32'd0);
      grant = (i == b.gdelay);
      tick();
    end
    grant = 1'b0;
    check("req_after_grant", 32'(req), 32'd0);
    idx = 1;
    stall_left = b.stall_cycles;
    held = 0;
    cyc = 0;
    while (idx <= b.len && cyc < b.len + b.stall_cycles + 4) begin
      check("tx_valid_send", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(flit(idx, b.len)));
      if (idx == b.stall_idx) held++;
      if (idx == b.stall_idx && stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
      tick();
      if (tx_ready) idx++;
      cyc++;
    end
    tx_ready = 1'b0;
    if (idx <= b.len) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got %0d flits expected %0d", idx - 1, b.len);
    end
    if (b.stall_idx != 0) check("held_cycles", 32'(held), 32'(b.stall_cycles + 1));
    check("tx_valid_end", 32'(tx_valid), 32'd0);
    check("cmd_ready_end", 32'(cmd_ready), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("burst dest=%0d len=%0d done", b.dest, b.len);
  endtask

  burst_t  bursts[4];
  rx_vec_t rx_tab[10];
  burst_t  tmp;

  initial begin
    bursts[0] = '{2, 3, 2, 0, 0};
    bursts[1] = '{2, 3, 2, 2, 3};
    bursts[2] = '{1, 1, 1, 0, 0};
    bursts[3] = '{3, 5, 3, 5, 2};

    rx_tab[0] = '{1'b1, 9'h001, 1, 0, 1'b0};
    rx_tab[1] = '{1'b1, 9'h002, 2, 0, 1'b0};
    rx_tab[2] = '{1'b0, 9'h0AA, 2, 0, 1'b0};
    rx_tab[3] = '{1'b1, 9'h103, 3, 1, 1'b0};
    rx_tab[4] = '{1'b1, 9'h001, 4, 1, 1'b0};
    rx_tab[5] = '{1'b1, 9'h102, 5, 2, 1'b0};
    rx_tab[6] = '{1'b1, 9'h001, 6, 2, 1'b0};
    rx_tab[7] = '{1'b1, 9'h003, 7, 2, 1'b1};
    rx_tab[8] = '{1'b1, 9'h004, 8, 2, 1'b1};
    rx_tab[9] = '{1'b1, 9'h105, 9, 3, 1'b1};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_dest = '0; cmd_len = '0;
    grant = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_req", 32'(req), 32'd0);
    check("rst_req_dest", 32'(req_dest), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flits", 32'(rx_flit_count), 32'd0);
    check("rst_pkts", 32'(rx_pkt_count), 32'd0);
    check("rst_err", 32'(rx_error), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_burst(bursts[i]);

    // Zero-length command is consumed without a request.
    cmd_valid = 1'b1; cmd_dest = 2'd1; cmd_len = 8'd0;
    check("len0_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("len0_req", 32'(req), 32'd0);
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_cmd_ready_after", 32'(cmd_ready), 32'd1);
      tick();
    end
    $display("len0 command done");

    // Maximum length: last only on seq 0xFF.
    tmp = '{3, 255, 1, 0, 0};
    run_burst(tmp);

    // RX table; TX must stay idle throughout.
    for (int i = 0; i < 10; i++) begin
      rx_valid = rx_tab[i].valid;
      rx_data  = rx_tab[i].data;
      tick();
      rx_valid = 1'b0;
      check("rx_flits", 32'(rx_flit_count), 32'(rx_tab[i].flits));
      check("rx_pkts", 32'(rx_pkt_count), 32'(rx_tab[i].pkts));
      check("rx_err", 32'(rx_error), 32'(rx_tab[i].err));
      check("rx_busy", 32'(busy), 32'd0);
      $display("rx v=%0d data=0x%03h flits=%0d pkts=%0d err=%0d", rx_tab[i].valid,
               rx_tab[i].data, rx_flit_count, rx_pkt_count, rx_error);
    end

    // Grant outside REQ is ignored; rx_error stays sticky.
    grant = 1'b1;
    repeat (2) tick();
    grant = 1'b0;
    check("stray_grant_req", 32'(req), 32'd0);
    check("stray_grant_tx_valid", 32'(tx_valid), 32'd0);
    check("stray_grant_busy", 32'(busy), 32'd0);
    check("err_sticky", 32'(rx_error), 32'd1);

    // Reset during SEND while seq=5 of 10 is presented.
    for (int i = 1; i <= 10; i++) sb.push_back(flit(i, 10));
    cmd_valid = 1'b1; cmd_dest = 2'd2; cmd_len = 8'd10;
    tick();
    cmd_valid = 1'b0;
    grant = 1'b1;
    tick();
    grant = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && !(tx_valid && tx_data == 9'h005); i++) tick();
    check("mid_seq5", 32'(tx_data), 32'h005);
    reset = 1'b1;
    #1;
    check("mid_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_req", 32'(req), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_err_cleared", 32'(rx_error), 32'd0);
    check("mid_flits_cleared", 32'(rx_flit_count), 32'd0);
    tx_ready = 1'b0;
    sb.delete();
    $display("reset mid-burst applied");
    tick();
    reset = 1'b0;
    tick();
    tmp = '{1, 2, 1, 0, 0};
    run_burst(tmp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
